// File: rtl/memcopy_sp.sv
// memcopy_sp: copies num words from src to dest through one single-port RAM, three cycles per word.
// Define MEMCOPY_OVERLAP_EN to copy backward when dest overlaps above src (memmove semantics).
module memcopy_sp #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dest,
    input  logic [ADDR_W-1:0] num,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wr_q,
    input  logic [DATA_W-1:0] rd_q,
    output logic              we,
    output logic              oe
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_CAP  = 3'd2,
        S_WR   = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   src_q;
    logic [ADDR_W-1:0]   dest_q;
    logic [ADDR_W-1:0]   num_q;
    logic [ADDR_W-1:0]   i_q;
    logic                bwd_q;
    logic                busy_q;
    logic                done_q;
    logic                we_q;
    logic                oe_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wr_data_q;

    logic                start_bwd_s;
    logic [ADDR_W:0]     i_inc_s;
    logic                more_s;
    logic [ADDR_W-1:0]   first_addr_s;
    logic [ADDR_W-1:0]   wr_addr_s;
    logic [ADDR_W-1:0]   next_rd_addr_s;

    // Address of word idx in a block; all arithmetic wraps modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] word_addr(
        input logic [ADDR_W-1:0] base,
        input logic [ADDR_W-1:0] n,
        input logic [ADDR_W-1:0] idx,
        input logic              bwd
    );
        logic [ADDR_W-1:0] res;
        if (bwd) begin
            res = base + n - {{(ADDR_W-1){1'b0}}, 1'b1} - idx;
        end else begin
            res = base + idx;
        end
        return res;
    endfunction

`ifdef MEMCOPY_OVERLAP_EN
    assign start_bwd_s = (dest > src) && ((dest - src) < num);
`else
    assign start_bwd_s = 1'b0;
`endif

    assign i_inc_s        = {1'b0, i_q} + {{ADDR_W{1'b0}}, 1'b1};
    assign more_s         = (i_inc_s < {1'b0, num_q});
    assign first_addr_s   = word_addr(src, num, {ADDR_W{1'b0}}, start_bwd_s);
    assign wr_addr_s      = word_addr(dest_q, num_q, i_q, bwd_q);
    assign next_rd_addr_s = word_addr(src_q, num_q, i_inc_s[ADDR_W-1:0], bwd_q);

    // Copy sequencer; RAM strobes are set on entry to RD/WR so every output is registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            src_q     <= {ADDR_W{1'b0}};
            dest_q    <= {ADDR_W{1'b0}};
            num_q     <= {ADDR_W{1'b0}};
            i_q       <= {ADDR_W{1'b0}};
            bwd_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            we_q      <= 1'b0;
            oe_q      <= 1'b0;
            addr_q    <= {ADDR_W{1'b0}};
            wr_data_q <= {DATA_W{1'b0}};
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    we_q   <= 1'b0;
                    oe_q   <= 1'b0;
                    if (start) begin
                        src_q  <= src;
                        dest_q <= dest;
                        num_q  <= num;
                        i_q    <= {ADDR_W{1'b0}};
                        bwd_q  <= start_bwd_s;
                        busy_q <= 1'b1;
                        if (num != {ADDR_W{1'b0}}) begin
                            state_q <= S_RD;
                            oe_q    <= 1'b1;
                            addr_q  <= first_addr_s;
                        end else begin
                            state_q <= S_FIN;
                        end
                    end
                end
                S_RD: begin
                    oe_q    <= 1'b0;
                    we_q    <= 1'b0;
                    state_q <= S_CAP;
                end
                S_CAP: begin
                    // rd_q is valid now, one cycle after the oe cycle.
                    wr_data_q <= rd_q;
                    we_q      <= 1'b1;
                    oe_q      <= 1'b0;
                    addr_q    <= wr_addr_s;
                    state_q   <= S_WR;
                end
                S_WR: begin
                    we_q <= 1'b0;
                    i_q  <= i_inc_s[ADDR_W-1:0];
                    if (more_s) begin
                        oe_q    <= 1'b1;
                        addr_q  <= next_rd_addr_s;
                        state_q <= S_RD;
                    end else begin
                        oe_q    <= 1'b0;
                        state_q <= S_FIN;
                    end
                end
                S_FIN: begin
                    we_q    <= 1'b0;
                    oe_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    we_q    <= 1'b0;
                    oe_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign addr = addr_q;
    assign wr_q = wr_data_q;
    assign we   = we_q;
    assign oe   = oe_q;

endmodule

// memcopy_sp_chk: protocol checker for memcopy_sp outputs.
module memcopy_sp_chk (
    input logic clk,
    input logic reset,
    input logic we,
    input logic oe,
    input logic busy,
    input logic done
);

    // RAM strobes are mutually exclusive and done never overlaps busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            assert (!(we && oe));
            assert (!(done && busy));
        end
    end

endmodule

// File: tb/tb_memcopy_sp.sv
// Scoreboard bench for memcopy_sp: expected RAM reads, writes and done latency are queued by stimulus.
module tb_memcopy_sp;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] src;
    logic [7:0] dest;
    logic [7:0] num;
    logic       busy;
    logic       done;
    logic [7:0] addr;
    logic [7:0] wr_q;
    logic [7:0] rd_q;
    logic       we;
    logic       oe;

    logic [7:0] mem  [256];
    logic [7:0] snap [256];

    logic [7:0]  exp_rd   [$];
    logic [15:0] exp_wr   [$];
    int          exp_done [$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int busy_cnt = 0;

    memcopy_sp #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk   (clk),
        .reset (rst_n),
        .start (start),
        .src   (src),
        .dest  (dest),
        .num   (num),
        .busy  (busy),
        .done  (done),
        .addr  (addr),
        .wr_q  (wr_q),
        .rd_q  (rd_q),
        .we    (we),
        .oe    (oe)
    );

    memcopy_sp_chk u_chk (
        .clk   (clk),
        .reset (rst_n),
        .we    (we),
        .oe    (oe),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Cycle counter and single-port RAM model with one-cycle read latency.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (oe) rd_q <= mem[addr];
        if (we) mem[addr] <= wr_q;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT strobes the RAM or pulses done.
    always @(negedge clk) begin
        if (rst_n) begin
            if (busy) busy_cnt++;
            if (we && oe) check("we_oe_exclusive", 32'(we && oe), 32'd0);
            if (oe) begin
                if (exp_rd.size() == 0) begin
                    check("unexpected_read_addr", 32'(addr), 32'hFFFF_FFFF);
                end else begin
                    check("rd_addr", 32'(addr), 32'(exp_rd.pop_front()));
                end
            end
            if (we) begin
                if (exp_wr.size() == 0) begin
                    check("unexpected_write_addr", 32'(addr), 32'hFFFF_FFFF);
                end else begin
                    logic [15:0] e;
                    e = exp_wr.pop_front();
                    check("wr_addr", 32'(addr), 32'(e[15:8]));
                    check("wr_data", 32'(wr_q), 32'(e[7:0]));
                end
            end
            if (done) begin
                if (exp_done.size() == 0) begin
                    check("unexpected_done_cycle", 32'(cyc - start_cyc + 1), 32'hFFFF_FFFF);
                end else begin
                    int l;
                    l = exp_done.pop_front();
                    check("done_cycle", 32'(cyc - start_cyc + 1), 32'(l));
                    check("busy_cycles", 32'(busy_cnt), 32'(l - 1));
                    check("busy_at_done", 32'(busy), 32'd0);
                end
            end
        end
    end

    task automatic clear_mem();
        for (int a = 0; a < 256; a++) mem[a] <= 8'h00;
    endtask

    task automatic load_ramp();
        clear_mem();
        for (int k = 0; k < 8; k++) mem[k] <= 8'(10 + k);
        @(negedge clk);
    endtask

    task automatic launch(input logic [7:0] s, input logic [7:0] d, input logic [7:0] n);
        @(negedge clk);
        start = 1'b1;
        src = s;
        dest = d;
        num = n;
        busy_cnt = 0;
        start_cyc = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain(input int ncyc, input string tag);
        repeat (ncyc) @(negedge clk);
        check({tag, "_reads_left"}, 32'(exp_rd.size()), 32'd0);
        check({tag, "_writes_left"}, 32'(exp_wr.size()), 32'd0);
        check({tag, "_done_left"}, 32'(exp_done.size()), 32'd0);
    endtask

    initial begin
        logic [7:0] fwd_tab [8];
        int diffs;
        fwd_tab = '{8'd10, 8'd11, 8'd12, 8'd13, 8'd10, 8'd11, 8'd12, 8'd13};

        rst_n = 1'b0;
        start = 1'b0;
        src = 8'd0;
        dest = 8'd0;
        num = 8'd0;
        clear_mem();
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_we", 32'(we), 32'd0);
        check("rst_oe", 32'(oe), 32'd0);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_wr_q", 32'(wr_q), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 8-word forward copy, non-overlapping.
        load_ramp();
        for (int k = 0; k < 8; k++) begin
            exp_rd.push_back(8'(k));
            exp_wr.push_back({8'(16 + k), 8'(10 + k)});
        end
        exp_done.push_back(26);
        launch(8'd0, 8'd16, 8'd8);
        drain(28, "t1");
        for (int k = 0; k < 8; k++) check("t1_ram", 32'(mem[16 + k]), 32'(10 + k));

        // num=0: done two cycles after start, no RAM access.
        for (int a = 0; a < 256; a++) snap[a] = mem[a];
        exp_done.push_back(2);
        launch(8'd5, 8'd200, 8'd0);
        drain(6, "t2");
        diffs = 0;
        for (int a = 0; a < 256; a++) if (mem[a] !== snap[a]) diffs++;
        check("t2_ram_unchanged", 32'(diffs), 32'd0);

        // Overlapping dest above src.
        load_ramp();
`ifdef MEMCOPY_OVERLAP_EN
        for (int k = 0; k < 8; k++) begin
            exp_rd.push_back(8'(7 - k));
            exp_wr.push_back({8'(11 - k), 8'(17 - k)});
        end
`else
        for (int k = 0; k < 8; k++) begin
            exp_rd.push_back(8'(k));
            exp_wr.push_back({8'(4 + k), fwd_tab[k]});
        end
`endif
        exp_done.push_back(26);
        launch(8'd0, 8'd4, 8'd8);
        drain(28, "t3");
        for (int k = 0; k < 8; k++) begin
`ifdef MEMCOPY_OVERLAP_EN
            check("t3_ram", 32'(mem[4 + k]), 32'(10 + k));
`else
            check("t3_ram", 32'(mem[4 + k]), 32'(fwd_tab[k]));
`endif
        end

        // Source wraps 255 -> 0; a second start while busy must be ignored.
        clear_mem();
        mem[254] <= 8'h21;
        mem[255] <= 8'h22;
        mem[0]   <= 8'h23;
        mem[1]   <= 8'h24;
        @(negedge clk);
        exp_rd.push_back(8'd254);
        exp_rd.push_back(8'd255);
        exp_rd.push_back(8'd0);
        exp_rd.push_back(8'd1);
        exp_wr.push_back({8'd100, 8'h21});
        exp_wr.push_back({8'd101, 8'h22});
        exp_wr.push_back({8'd102, 8'h23});
        exp_wr.push_back({8'd103, 8'h24});
        exp_done.push_back(14);
        launch(8'd254, 8'd100, 8'd4);
        repeat (4) @(negedge clk);
        start = 1'b1;
        src = 8'd50;
        dest = 8'd60;
        num = 8'd9;
        @(negedge clk);
        start = 1'b0;
        drain(12, "t4");
        check("t4_ram100", 32'(mem[100]), 32'h21);
        check("t4_ram103", 32'(mem[103]), 32'h24);

        // Reset during word 3 of an 8-word copy aborts it.
        load_ramp();
        for (int k = 0; k < 4; k++) exp_rd.push_back(8'(k));
        for (int k = 0; k < 3; k++) exp_wr.push_back({8'(32 + k), 8'(10 + k)});
        launch(8'd0, 8'd32, 8'd8);
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_oe", 32'(oe), 32'd0);
        check("t5_async_we", 32'(we), 32'd0);
        check("t5_async_busy", 32'(busy), 32'd0);
        check("t5_async_addr", 32'(addr), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        drain(4, "t5");
        check("t5_ram32", 32'(mem[32]), 32'd10);
        check("t5_ram34", 32'(mem[34]), 32'd12);
        check("t5_ram35_untouched", 32'(mem[35]), 32'd0);
        check("t5_ram39_untouched", 32'(mem[39]), 32'd0);

        // Fresh copy after reset release.
        exp_rd.push_back(8'd0);
        exp_rd.push_back(8'd1);
        exp_wr.push_back({8'd64, 8'd10});
        exp_wr.push_back({8'd65, 8'd11});
        exp_done.push_back(8);
        launch(8'd0, 8'd64, 8'd2);
        drain(10, "t6");
        check("t6_ram64", 32'(mem[64]), 32'd10);
        check("t6_ram65", 32'(mem[65]), 32'd11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/memcopy_sp.md
MEMCOPY_SP -- requirements
Module: memcopy_sp

Parameters
REQ-001 SHALL have parameter ADDR_W, default 8, width of RAM address, src, dest and num.
REQ-002 SHALL have parameter DATA_W, default 8, width of RAM data words.

Interface
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle copy request; sampled only in IDLE.
REQ-006 src  input  ADDR_W  first source word address; latched on accepted start.
REQ-007 dest  input  ADDR_W  first destination word address; latched on accepted start.
REQ-008 num  input  ADDR_W  word count; latched on accepted start.
REQ-009 busy  output  1  high from the cycle after accepted start until done.
REQ-010 done  output  1  one-cycle pulse when the copy completes.
REQ-011 addr  output  ADDR_W  single-port RAM address.
REQ-012 wr_q  output  DATA_W  RAM write data.
REQ-013 rd_q  input  DATA_W  RAM read data; valid one cycle after an oe cycle.
REQ-014 we  output  1  RAM write enable.
REQ-015 oe  output  1  RAM read enable.

Function
REQ-016 SHALL implement FSM states IDLE, RD, CAP, WR, FIN.
REQ-017 IDLE: on start=1, SHALL latch src, dest, num, clear word index i; next state RD if num!=0, else FIN.
REQ-018 RD: SHALL drive oe=1, we=0, addr=source address of word i; next state CAP.
REQ-019 CAP: SHALL drive oe=0, we=0; SHALL register rd_q into a data register at end of cycle; next state WR.
REQ-020 WR: SHALL drive we=1, oe=0, addr=destination address of word i, wr_q=data register; increment i; next RD if i+1<num, else FIN.
REQ-021 FIN: SHALL assert done=1 for exactly one cycle, busy=0 from the next cycle; next state IDLE.
REQ-022 we and oe SHALL never both be high; outside RD/WR both SHALL be 0.
REQ-023 Address arithmetic SHALL be modulo 2^ADDR_W (wrap-around 255 -> 0 for ADDR_W=8).
REQ-024 Copy of num words SHALL take exactly 3*num+2 cycles from start edge to done pulse inclusive; num=0 gives done 2 cycles after start with no RAM access.
REQ-025 start while busy SHALL be ignored; src/dest/num changes while busy SHALL not affect the copy.
REQ-026 In IDLE, addr and wr_q SHALL hold their last values; only we/oe matter to the RAM.

Reset
REQ-027 reset low SHALL immediately force state IDLE, busy=0, done=0, we=0, oe=0, addr=0, wr_q=0, i=0.
REQ-028 Reset mid-copy SHALL abort with no further RAM writes; already-written words remain; no done pulse.

Configuration
REQ-029 Macro MEMCOPY_OVERLAP_EN: when defined, if dest>src and dest-src<num (modulo-free compare on latched values), copy SHALL proceed backward (word i uses src+num-1-i, dest+num-1-i), otherwise forward; result equals memmove semantics.
REQ-030 Without MEMCOPY_OVERLAP_EN, copy SHALL always proceed forward (word i uses src+i, dest+i); overlapping dest>src regions yield replicated data.

Verification
REQ-031 RAM preloaded 0..7 = 10..17, start src=0 dest=16 num=8 -> RAM 16..23 = 10..17, done at cycle 26 after start, busy high cycles 1..25.
REQ-032 start with num=0 -> done 2 cycles later, we/oe never asserted, RAM unchanged.
REQ-033 RAM 0..7 = 10..17, src=0 dest=4 num=8 -> with MEMCOPY_OVERLAP_EN RAM 4..11 = 10..17; without it RAM 4..11 = 10,11,12,13,10,11,12,13.
REQ-034 src=254 dest=100 num=4 -> reads addrs 254,255,0,1 in order; RAM 100..103 = their prior contents.
REQ-035 reset low during word 3 of an 8-word copy -> we/oe drop asynchronously, words 0..2 written, word 3+ untouched, no done; new start after release completes normally.
REQ-036 Every cycle: assertion we&oe==0; second start pulse during busy -> no effect on addresses or timing.
